// File: rtl/wf68k30L_pkg.sv
// -----------------------------------------------------------------------------
// wf68k30L_pkg
// Shared definitions for the WF68K30L execution/writeback path: operation
// enumeration, exec/writeback sequencer state encodings, destination-class
// codes, the captured-operation payload and a count clamp helper.
// -----------------------------------------------------------------------------
package wf68k30L_pkg;

    localparam int unsigned STATE_W    = 3;
    localparam int unsigned KIND_W     = 2;
    localparam int unsigned REG_CNT_W  = 3;
    localparam int unsigned BEAT_CNT_W = 4;
    localparam int unsigned WB_IDX_W   = 2;
    localparam int unsigned BEAT_IDX_W = 3;

    // Operation classes decoded by the control block.
    typedef enum logic [4:0] {
        OP_NOP,
        OP_ABCD,
        OP_ADD,
        OP_ADDA,
        OP_AND,
        OP_CLR,
        OP_CMP,
        OP_EXG,
        OP_LEA,
        OP_MOVE,
        OP_MOVEA,
        OP_MOVEM,
        OP_PEA,
        OP_SUB,
        OP_TST
    } op_e;

    // Exec/writeback sequencer states (legacy-compatible numbering).
    localparam logic [STATE_W-1:0] ST_IDLE         = 3'd0;
    localparam logic [STATE_W-1:0] ST_EXECUTE      = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADR_PIPELINE = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITEBACK    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE_DEST   = 3'd4;

    // Destination classes.
    localparam logic [KIND_W-1:0] DK_NONE    = 2'd0;
    localparam logic [KIND_W-1:0] DK_REG     = 2'd1;
    localparam logic [KIND_W-1:0] DK_MEM     = 2'd2;
    localparam logic [KIND_W-1:0] DK_MEM_ADR = 2'd3;

    // Fields latched when the ALU result is taken.
    typedef struct packed {
        logic [KIND_W-1:0]     kind;
        logic [REG_CNT_W-1:0]  reg_cnt;
        logic [BEAT_CNT_W-1:0] beat_cnt;
    } wb_cap_t;

    // Zero means one; anything above the limit saturates at the limit.
    function automatic logic [BEAT_CNT_W-1:0] clamp_cnt(
        input logic [BEAT_CNT_W-1:0] cnt,
        input logic [BEAT_CNT_W-1:0] max_cnt
    );
        logic [BEAT_CNT_W-1:0] res;
        res = cnt;
        if (cnt == 4'd0) begin
            res = 4'd1;
        end else if (cnt > max_cnt) begin
            res = max_cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/wf68k30l_exec_wb_seq_if.sv
// -----------------------------------------------------------------------------
// wf68k30l_exec_wb_seq_if
// Control/bus handshake bundle of the exec/writeback sequencer.
//   master : control block / bus side (drives FLUSH..WR_RDY, observes status)
//   slave  : the sequencer (observes requests, drives state/strobes/DONE)
// -----------------------------------------------------------------------------
interface wf68k30l_exec_wb_seq_if;

    logic       FLUSH;
    logic       ALU_INIT;
    logic       ALU_REQ;
    logic       HOLD;
    logic       DISCARD;
    logic [1:0] DEST_KIND;
    logic [2:0] REG_CNT;
    logic [3:0] BEAT_CNT;
    logic       WR_RDY;

    logic [2:0] EXEC_WB_STATE;
    logic       WB_STROBE;
    logic [1:0] WB_INDEX;
    logic       WR_REQ;
    logic [2:0] WR_BEAT;
    logic       BUSY;
    logic       DONE;

    modport master (
        output FLUSH, ALU_INIT, ALU_REQ, HOLD, DISCARD,
        output DEST_KIND, REG_CNT, BEAT_CNT, WR_RDY,
        input  EXEC_WB_STATE, WB_STROBE, WB_INDEX, WR_REQ, WR_BEAT, BUSY, DONE
    );

    modport slave (
        input  FLUSH, ALU_INIT, ALU_REQ, HOLD, DISCARD,
        input  DEST_KIND, REG_CNT, BEAT_CNT, WR_RDY,
        output EXEC_WB_STATE, WB_STROBE, WB_INDEX, WR_REQ, WR_BEAT, BUSY, DONE
    );

endinterface

// File: rtl/wf68k30l_exec_wb_seq.sv
// -----------------------------------------------------------------------------
// wf68k30l_exec_wb_seq
// Sequences one ALU operation from acceptance to retirement: waits for the
// result, then performs register writebacks or memory destination beats
// (optionally preceded by an address cycle per beat), pulsing DONE on retire.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : slave side of the handshake bundle (requests in, status out)
// Parameters:
//   MAX_BEATS : max memory beats per operation (1..8)
//   WB_REGS   : max register writebacks per operation (1..4)
// -----------------------------------------------------------------------------
module wf68k30l_exec_wb_seq #(
    parameter int unsigned MAX_BEATS = 5,
    parameter int unsigned WB_REGS   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    wf68k30l_exec_wb_seq_if.slave    bus
);
    import wf68k30L_pkg::*;

    localparam logic [BEAT_CNT_W-1:0] REG_LIMIT  = BEAT_CNT_W'(WB_REGS);
    localparam logic [BEAT_CNT_W-1:0] BEAT_LIMIT = BEAT_CNT_W'(MAX_BEATS);

    logic [STATE_W-1:0]    state_q, state_d;
    wb_cap_t               cap_q, cap_d;
    logic [WB_IDX_W-1:0]   idx_q, idx_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;

    logic                  wb_strobe_q, wb_strobe_d;
    logic [WB_IDX_W-1:0]   wb_index_q, wb_index_d;
    logic                  wr_req_q, wr_req_d;
    logic [BEAT_IDX_W-1:0] wr_beat_q, wr_beat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  last_wb;
    logic                  last_beat;

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        beat_d  = beat_q;

        last_wb   = ({1'b0, idx_q} == (cap_q.reg_cnt - 3'd1));
        last_beat = ({1'b0, beat_q} == (cap_q.beat_cnt - 4'd1));

        if (bus.FLUSH) begin
            state_d = ST_IDLE;
            cap_d   = '0;
            idx_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ALU_INIT) begin
                        state_d = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (bus.ALU_REQ && !bus.HOLD) begin
                        cap_d.kind     = bus.DEST_KIND;
                        cap_d.reg_cnt  = REG_CNT_W'(clamp_cnt({1'b0, bus.REG_CNT}, REG_LIMIT));
                        cap_d.beat_cnt = clamp_cnt(bus.BEAT_CNT, BEAT_LIMIT);
                        idx_d          = '0;
                        beat_d         = '0;
                        if (bus.DISCARD) begin
                            state_d = ST_IDLE;
                        end else begin
                            case (bus.DEST_KIND)
                                DK_REG:     state_d = ST_WRITEBACK;
                                DK_MEM:     state_d = ST_WRITE_DEST;
                                DK_MEM_ADR: state_d = ST_ADR_PIPELINE;
                                default:    state_d = ST_IDLE;
                            endcase
                        end
                    end
                end
                ST_ADR_PIPELINE: begin
                    state_d = ST_WRITE_DEST;
                end
                ST_WRITEBACK: begin
                    if (last_wb) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                ST_WRITE_DEST: begin
                    if (bus.WR_RDY) begin
                        if (last_beat) begin
                            state_d = ST_IDLE;
                            beat_d  = '0;
                        end else begin
                            // Every further beat re-runs the address cycle.
                            state_d = ST_ADR_PIPELINE;
                            beat_d  = beat_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cap_d   = '0;
                    idx_d   = '0;
                    beat_d  = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the flops present them
        // in the same cycle as the state they describe.
        wb_strobe_d = (state_d == ST_WRITEBACK);
        wb_index_d  = (state_d == ST_WRITEBACK) ? idx_d : '0;
        wr_req_d    = (state_d == ST_WRITE_DEST);
        wr_beat_d   = beat_d;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_IDLE) && (state_q != ST_IDLE) && !bus.FLUSH;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cap_q       <= '0;
            idx_q       <= '0;
            beat_q      <= '0;
            wb_strobe_q <= 1'b0;
            wb_index_q  <= '0;
            wr_req_q    <= 1'b0;
            wr_beat_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            wb_strobe_q <= wb_strobe_d;
            wb_index_q  <= wb_index_d;
            wr_req_q    <= wr_req_d;
            wr_beat_q   <= wr_beat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.EXEC_WB_STATE = state_q;
    assign bus.WB_STROBE     = wb_strobe_q;
    assign bus.WB_INDEX      = wb_index_q;
    assign bus.WR_REQ        = wr_req_q;
    assign bus.WR_BEAT       = wr_beat_q;
    assign bus.BUSY          = busy_q;
    assign bus.DONE          = done_q;

endmodule

// File: tb/tb_wf68k30l_exec_wb_seq.sv
// -----------------------------------------------------------------------------
// tb_wf68k30l_exec_wb_seq
// Scoreboard bench for the exec/writeback sequencer: directed operations push
// expected writeback/beat/DONE events, an independent monitor pops and compares
// them as the DUT presents them; state and timing checks are done inline.
// -----------------------------------------------------------------------------
module tb_wf68k30l_exec_wb_seq;
    import wf68k30L_pkg::*;

    localparam int EV_WB   = 0;
    localparam int EV_WR   = 1;
    localparam int EV_DONE = 2;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   rdy_delay = 0;
    int   rdy_cnt = 0;
    ev_t  exp_q[$];

    wf68k30l_exec_wb_seq_if bus();

    wf68k30l_exec_wb_seq #(.MAX_BEATS(5), .WB_REGS(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = 2'(k);
        e.val  = 4'(v);
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int k, input int n);
        for (int i = 0; i < n; i++) push_ev(k, i);
    endtask

    task automatic take_ev(input int k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d value %0d expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard_event(kind*16+value)", k * 16 + v, int'(e.kind) * 16 + int'(e.val));
        end
    endtask

    // Monitor: every presented output event is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.WB_STROBE === 1'b1) take_ev(EV_WB, int'(bus.WB_INDEX));
                if (bus.WR_REQ === 1'b1 && bus.WR_RDY === 1'b1) take_ev(EV_WR, int'(bus.WR_BEAT));
                if (bus.DONE === 1'b1) take_ev(EV_DONE, 0);
            end
        end
    end

    // Bus responder: accept each write beat after rdy_delay wait cycles.
    initial begin
        bus.WR_RDY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.WR_REQ === 1'b1) begin
                if (rdy_cnt >= rdy_delay) begin
                    bus.WR_RDY = 1'b1;
                    rdy_cnt    = 0;
                end else begin
                    bus.WR_RDY = 1'b0;
                    rdy_cnt++;
                end
            end else begin
                bus.WR_RDY = 1'b0;
                rdy_cnt    = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_zero(input string tag);
        check({tag, "_state"}, int'(bus.EXEC_WB_STATE), 0);
        check({tag, "_wb_strobe"}, int'(bus.WB_STROBE), 0);
        check({tag, "_wb_index"}, int'(bus.WB_INDEX), 0);
        check({tag, "_wr_req"}, int'(bus.WR_REQ), 0);
        check({tag, "_wr_beat"}, int'(bus.WR_BEAT), 0);
        check({tag, "_busy"}, int'(bus.BUSY), 0);
        check({tag, "_done"}, int'(bus.DONE), 0);
    endtask

    // Accept an operation, optionally stall with HOLD, and hand over the result.
    // Returns #1 after the capture edge.
    task automatic start_op(input int kind, input int rc, input int bc,
                            input int disc, input int hold);
        @(posedge clk); #1;
        bus.ALU_INIT = 1'b1;
        @(posedge clk); #1;
        check("init_to_execute", int'(bus.EXEC_WB_STATE), int'(ST_EXECUTE));
        bus.ALU_INIT  = 1'b0;
        bus.ALU_REQ   = 1'b1;
        bus.HOLD      = (hold > 0);
        bus.DEST_KIND = 2'(kind);
        bus.REG_CNT   = 3'(rc);
        bus.BEAT_CNT  = 4'(bc);
        bus.DISCARD   = (disc != 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stays_execute", int'(bus.EXEC_WB_STATE), int'(ST_EXECUTE));
            if (i == hold - 1) bus.HOLD = 1'b0;
        end
        @(posedge clk); #1;
        bus.ALU_REQ   = 1'b0;
        bus.DISCARD   = 1'b0;
        bus.DEST_KIND = '0;
        bus.REG_CNT   = '0;
        bus.BEAT_CNT  = '0;
    endtask

    task automatic run_op(input string name, input int kind, input int rc, input int bc,
                          input int disc, input int hold, input int init_mid,
                          input int delay, input int exp_state, input int exp_cycles);
        int cycles;
        rdy_delay = delay;
        start_op(kind, rc, bc, disc, hold);
        check({name, "_first_state"}, int'(bus.EXEC_WB_STATE), exp_state);
        if (init_mid != 0) bus.ALU_INIT = 1'b1;
        cycles = 0;
        while (bus.EXEC_WB_STATE != ST_IDLE && cycles < 300) begin
            cycles++;
            @(posedge clk); #1;
            bus.ALU_INIT = 1'b0;
        end
        check({name, "_busy_cycles"}, cycles, exp_cycles);
        @(negedge clk);
        @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int found;
        bus.FLUSH = 1'b0; bus.ALU_INIT = 1'b0; bus.ALU_REQ = 1'b0;
        bus.HOLD = 1'b0; bus.DISCARD = 1'b0; bus.DEST_KIND = '0;
        bus.REG_CNT = '0; bus.BEAT_CNT = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");

        // First edge after release already moves; then flush back without DONE.
        rst = 1'b0;
        bus.ALU_INIT = 1'b1;
        @(posedge clk); #1;
        check("first_edge_after_reset", int'(bus.EXEC_WB_STATE), int'(ST_EXECUTE));
        bus.ALU_INIT = 1'b0;
        bus.FLUSH    = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        check("flush_exec_state", int'(bus.EXEC_WB_STATE), int'(ST_IDLE));
        check("flush_exec_done", int'(bus.DONE), 0);

        // Register destination, two writebacks.
        push_seq(EV_WB, 2); push_ev(EV_DONE, 0);
        run_op("reg2", 1, 2, 0, 0, 0, 0, 0, int'(ST_WRITEBACK), 2);

        // Memory with address cycle, five beats, two wait cycles each.
        push_seq(EV_WR, 5); push_ev(EV_DONE, 0);
        run_op("memadr5", 3, 0, 5, 0, 0, 0, 2, int'(ST_ADR_PIPELINE), 20);

        // HOLD for three cycles, capture when it falls.
        push_seq(EV_WB, 1); push_ev(EV_DONE, 0);
        run_op("hold3", 1, 1, 0, 0, 3, 0, 0, int'(ST_WRITEBACK), 1);

        // Clamping.
        push_seq(EV_WR, 1); push_ev(EV_DONE, 0);
        run_op("beat0", 2, 0, 0, 0, 0, 0, 0, int'(ST_WRITE_DEST), 1);
        push_seq(EV_WR, 5); push_ev(EV_DONE, 0);
        run_op("beat12", 2, 0, 12, 0, 0, 0, 0, int'(ST_WRITE_DEST), 9);
        push_seq(EV_WB, 2); push_ev(EV_DONE, 0);
        run_op("reg7", 1, 7, 0, 0, 0, 0, 0, int'(ST_WRITEBACK), 2);
        push_seq(EV_WB, 1); push_ev(EV_DONE, 0);
        run_op("reg0", 1, 0, 0, 0, 0, 0, 0, int'(ST_WRITEBACK), 1);

        // No destination and discarded writes retire straight away.
        push_ev(EV_DONE, 0);
        run_op("none", 0, 2, 3, 0, 0, 0, 0, int'(ST_IDLE), 0);
        push_ev(EV_DONE, 0);
        run_op("discard", 2, 2, 3, 1, 0, 0, 0, int'(ST_IDLE), 0);

        // ALU_INIT while busy is ignored.
        push_seq(EV_WR, 3); push_ev(EV_DONE, 0);
        run_op("init_busy", 2, 0, 3, 0, 0, 1, 1, int'(ST_WRITE_DEST), 8);

        // Flush during beat 3.
        rdy_delay = 2;
        push_seq(EV_WR, 3);
        start_op(3, 0, 5, 0, 0);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(posedge clk); #1;
            if (bus.WR_REQ === 1'b1 && bus.WR_BEAT == 3'd3) found = 1;
        end
        check("flush_reached_beat3", found, 1);
        bus.FLUSH = 1'b1;
        @(posedge clk); #1;
        bus.FLUSH = 1'b0;
        check("flush_beat_state", int'(bus.EXEC_WB_STATE), int'(ST_IDLE));
        check("flush_beat_wr_req", int'(bus.WR_REQ), 0);
        check("flush_beat_done", int'(bus.DONE), 0);
        check("flush_beat_wr_beat", int'(bus.WR_BEAT), 0);
        @(negedge clk); @(negedge clk);
        check("flush_drained", exp_q.size(), 0);

        // Async reset in the middle of WRITEBACK.
        rdy_delay = 0;
        push_seq(EV_WB, 1);
        start_op(1, 2, 0, 0, 0);
        check("rst_wb_state", int'(bus.EXEC_WB_STATE), int'(ST_WRITEBACK));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid_wb");
        @(negedge clk);
        rst = 1'b0;
        check("rst_wb_drained", exp_q.size(), 0);

        // Async reset in WRITE_DEST while WR_RDY is asserted.
        start_op(2, 0, 2, 0, 0);
        check("rst_wd_rdy_pending", int'(bus.WR_RDY), 1);
        #1 rst = 1'b1;
        #1 check_zero("rst_mid_wd");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wd_idle", int'(bus.EXEC_WB_STATE), int'(ST_IDLE));
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wf68k30l_exec_wb_seq.md
WF68K30L_EXEC_WB_SEQ -- requirements
Module: wf68k30l_exec_wb_seq

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 5, meaning maximum destination write beats per operation (range 1..8).
REQ-002 SHALL have parameter WB_REGS, default 2, meaning maximum register writebacks per operation (range 1..4).
REQ-003 SHALL have port CLK, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RESET, input, 1, meaning reset; it is asynchronous and active-high.
REQ-005 SHALL have port FLUSH, input, 1, meaning synchronous abort of the current operation (exception or pipeline flush).
REQ-006 SHALL have port ALU_INIT, input, 1, meaning the ALU has accepted a new operation.
REQ-007 SHALL have port ALU_REQ, input, 1, meaning the ALU result is valid.
REQ-008 SHALL have port HOLD, input, 1, meaning the destination address is not ready yet (PHASE2 wait).
REQ-009 SHALL have port DISCARD, input, 1, meaning the write is inhibited (MOVEM inhibit).
REQ-010 SHALL have port DEST_KIND, input, 2, meaning the destination class: 0 NONE, 1 REG, 2 MEM, 3 MEM_ADR (memory destination that needs an address cycle first).
REQ-011 SHALL have port REG_CNT, input, 3, meaning the number of register writebacks requested.
REQ-012 SHALL have port BEAT_CNT, input, 4, meaning the number of memory beats requested.
REQ-013 SHALL have port WR_RDY, input, 1, meaning the bus has accepted the current write beat.
REQ-014 SHALL have port EXEC_WB_STATE, output, 3, meaning the current state: 0 IDLE, 1 EXECUTE, 2 ADR_PIPELINE, 3 WRITEBACK, 4 WRITE_DEST.
REQ-015 SHALL have port WB_STROBE, output, 1, meaning a register write this cycle.
REQ-016 SHALL have port WB_INDEX, output, 2, meaning the index of the register being written (0 = first).
REQ-017 SHALL have port WR_REQ, output, 1, meaning a memory write beat request.
REQ-018 SHALL have port WR_BEAT, output, 3, meaning the index of the current write beat.
REQ-019 SHALL have port BUSY, output, 1, meaning the state is not IDLE.
REQ-020 SHALL have port DONE, output, 1, meaning a one-cycle pulse marking operation retirement.

Function
REQ-021 SHALL move from IDLE to EXECUTE on ALU_INIT; otherwise it SHALL stay in IDLE.
REQ-022 In EXECUTE, SHALL wait while ALU_REQ=0 or HOLD=1.
REQ-023 On ALU_REQ=1 and HOLD=0, SHALL capture DEST_KIND, REG_CNT and BEAT_CNT.
REQ-024 Capture clamping: a count of 0 SHALL be treated as 1; REG_CNT above WB_REGS SHALL be clamped to WB_REGS; BEAT_CNT above MAX_BEATS SHALL be clamped to MAX_BEATS.
REQ-025 Exit from EXECUTE (on capture) SHALL go to: IDLE if DISCARD=1 or DEST_KIND=NONE; WRITEBACK if REG; WRITE_DEST if MEM; ADR_PIPELINE if MEM_ADR.
REQ-026 ADR_PIPELINE SHALL last exactly one cycle, then go to WRITE_DEST.
REQ-027 WRITEBACK SHALL last exactly the captured REG_CNT cycles.
REQ-028 In WRITEBACK, WB_STROBE SHALL be 1 and WB_INDEX SHALL count 0..REG_CNT-1; after the last index the state SHALL go to IDLE.
REQ-029 In WRITE_DEST, WR_REQ SHALL be 1 and WR_BEAT SHALL hold the beat index; the state SHALL hold until WR_RDY=1.
REQ-030 On WR_RDY in WRITE_DEST: a non-final beat SHALL increment WR_BEAT and go to ADR_PIPELINE; the final beat SHALL go to IDLE.
REQ-031 DONE SHALL pulse for one cycle on every transition into IDLE except one caused by FLUSH or RESET.
REQ-032 FLUSH SHALL take priority over all other inputs: next state IDLE, counters zeroed, no DONE pulse.
REQ-033 ALU_INIT arriving while the block is not in IDLE SHALL be ignored.
REQ-034 WB_STROBE, WB_INDEX, WR_REQ, WR_BEAT and BUSY SHALL be Moore outputs decoded from registered state and counters, with no combinational input-to-output path.

Reset
REQ-035 RESET SHALL force state IDLE, all counters and captured fields 0, and all outputs 0, including in the middle of WRITE_DEST with WR_RDY pending.
REQ-036 The first transition after RESET is released SHALL occur on the first rising CLK edge with RESET=0.

Structure
REQ-037 State encodings and DEST_KIND codes SHALL live in the shared package wf68k30L_pkg, next to the operation enumeration.
REQ-038 The block SHALL use a single-process next-state decode plus a registered state/counter process, with no sub-modules.
REQ-039 The legacy opcode-to-DEST_KIND mapping SHALL stay in the control block that drives this module.

Verification
REQ-040 REG case: ALU_INIT, then ALU_REQ with DEST_KIND=1 and REG_CNT=2 -> two WRITEBACK cycles with WB_INDEX 0 then 1, followed by DONE.
REQ-041 MEM_ADR case: DEST_KIND=3, BEAT_CNT=5, WR_RDY after 2 wait cycles per beat -> states ADR,WD,WD,WD,ADR,... with WR_BEAT stepping 0..4, then DONE once.
REQ-042 HOLD case: HOLD=1 for 3 cycles with ALU_REQ=1 -> state stays EXECUTE; capture happens on the cycle HOLD falls.
REQ-043 Clamp case: BEAT_CNT=0 -> exactly 1 beat; BEAT_CNT=12 -> MAX_BEATS beats; REG_CNT=7 -> WB_REGS writebacks.
REQ-044 Flush case: FLUSH during beat 3 of WRITE_DEST -> IDLE next cycle, WR_REQ=0, no DONE.
REQ-045 Reset case: async RESET mid-WRITEBACK -> all outputs 0 immediately; DISCARD=1 at capture -> IDLE with DONE and no writes.
